// File: rtl/sensor_hub_pkg.sv
// Shared constants for the sensor hub: ASCII message bytes and the formatter FSM state encoding.
// Also holds the BCD-nibble to ASCII digit helper.
package sensor_hub_pkg;

  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_CONV      = 3'd1;
  localparam state_t ST_LOAD      = 3'd2;
  localparam state_t ST_WAIT_ACK  = 3'd3;
  localparam state_t ST_WAIT_DONE = 3'd4;

  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// 8-bit binary to 3-digit BCD, shift-and-add-3, one shift per cycle; done_o flags the cycle of the 8th shift.
// A start_i pulse reloads the converter; outputs hold their value until the next start_i.
module bin2bcd8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] bin_i,
  output logic       done_o,
  output logic [3:0] hund_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  // {hundreds, tens, ones, binary}; the binary part shifts out the top into the BCD digits
  logic [19:0] sr_q, sr_d, adj;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;

  always_comb begin
    adj = sr_q;
    if (adj[11:8] >= 4'd5)  adj[11:8]  = adj[11:8]  + 4'd3;
    if (adj[15:12] >= 4'd5) adj[15:12] = adj[15:12] + 4'd3;
    if (adj[19:16] >= 4'd5) adj[19:16] = adj[19:16] + 4'd3;
  end

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      sr_d   = {12'h000, bin_i};
      cnt_d  = 3'd0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      sr_d  = {adj[18:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done_o = busy_q && (cnt_q == 3'd7);
  assign hund_o = sr_q[19:16];
  assign tens_o = sr_q[15:12];
  assign ones_o = sr_q[11:8];

endmodule

// File: rtl/temp_ascii_formatter.sv
// Formats a signed temperature sample as "T+ddd\r\n" bytes for a UART; first tx_start 10 cycles after accept.
// Samples arriving while not ready are dropped and counted; a UART that never goes busy aborts the message.
module temp_ascii_formatter
  import sensor_hub_pkg::*;
#(
  parameter logic [7:0]  PREFIX      = 8'h54,
  parameter bit          CRLF        = 1'b1,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       temp_valid,
  input  logic [7:0] temp_data,
  output logic       ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [7:0] drop_cnt,
  output logic       ack_err
);

  localparam int unsigned TO_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [2:0]  LAST_IDX = CRLF ? 3'd6 : 3'd5;

  state_t          state_q, state_d;
  logic            sign_q, sign_d;
  logic [7:0]      mag_q, mag_d;
  logic [2:0]      idx_q, idx_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [7:0]      drop_q, drop_d;
  logic            ack_err_q, ack_err_d;
  logic            start_q, start_d;

  logic            accept;
  logic            bcd_done;
  logic [3:0]      hund, tens, ones;
  logic [2:0]      sel;
  logic [7:0]      sel_byte;

  assign ready  = rst_n && (state_q == ST_IDLE);
  assign accept = temp_valid && ready;

  bin2bcd8 u_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_q),
    .bin_i   (mag_q),
    .done_o  (bcd_done),
    .hund_o  (hund),
    .tens_o  (tens),
    .ones_o  (ones)
  );

  // Index of the byte about to be loaded: 0 on leaving CONV, next index on leaving WAIT_DONE
  assign sel = (state_q == ST_WAIT_DONE) ? idx_q + 3'd1 : 3'd0;

  always_comb begin
    sel_byte = ASCII_LF;
    case (sel)
      3'd0:    sel_byte = PREFIX;
      3'd1:    sel_byte = sign_q ? ASCII_MINUS : ASCII_PLUS;
      3'd2:    sel_byte = bcd_to_ascii(hund);
      3'd3:    sel_byte = bcd_to_ascii(tens);
      3'd4:    sel_byte = bcd_to_ascii(ones);
      3'd5:    sel_byte = CRLF ? ASCII_CR : ASCII_LF;
      default: sel_byte = ASCII_LF;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    idx_d     = idx_q;
    to_d      = to_q;
    tx_data_d = tx_data_q;
    ack_err_d = ack_err_q;
    start_d   = 1'b0;
    drop_d    = drop_q;
    if (temp_valid && !ready && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sign_d  = temp_data[7];
          mag_d   = temp_data[7] ? (~temp_data + 8'd1) : temp_data;
          idx_d   = 3'd0;
          start_d = 1'b1;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        if (bcd_done) begin
          tx_data_d = sel_byte;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        to_d    = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (to_q == TO_W'(ACK_TIMEOUT - 1)) begin
          ack_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = sel_byte;
            state_d   = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      idx_q     <= '0;
      to_q      <= '0;
      tx_data_q <= '0;
      drop_q    <= '0;
      ack_err_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      idx_q     <= idx_d;
      to_q      <= to_d;
      tx_data_q <= tx_data_d;
      drop_q    <= drop_d;
      ack_err_q <= ack_err_d;
      start_q   <= start_d;
    end
  end

  assign tx_start = (state_q == ST_LOAD);
  assign tx_data  = tx_data_q;
  assign drop_cnt = drop_q;
  assign ack_err  = ack_err_q;

endmodule

// File: tb/tb_temp_ascii_formatter.sv
// Bench for temp_ascii_formatter: two instances (CR+LF and LF-only), a UART busy model per instance,
// a byte monitor, spec-derived vector table, directed corner sequences and randomized messages.
module tb_temp_ascii_formatter;

  typedef logic [7:0] bq_t [$];
  typedef struct packed {
    logic        inst;
    logic [7:0]  val;
    int          blen;
    logic [55:0] exp;
    int          n;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      tv, busy, rdy, st, aerr;
  logic [1:0][7:0] td, txd, drop;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   viol = 0;
  int   busy_len [2];
  bit   uart_en [2];
  int   ucnt [2];
  logic [7:0] last_b [2];
  logic [7:0] got0 [$];
  logic [7:0] got1 [$];
  int   sc0 [$];
  int   sc1 [$];
  vec_t vecs [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  temp_ascii_formatter #(.PREFIX(8'h54), .CRLF(1'b1), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .temp_valid(tv[0]), .temp_data(td[0]), .ready(rdy[0]),
    .tx_start(st[0]), .tx_data(txd[0]), .tx_busy(busy[0]), .drop_cnt(drop[0]), .ack_err(aerr[0]));

  temp_ascii_formatter #(.PREFIX(8'h54), .CRLF(1'b0), .ACK_TIMEOUT(4)) dut_lf (
    .clk(clk), .rst_n(rst_n), .temp_valid(tv[1]), .temp_data(td[1]), .ready(rdy[1]),
    .tx_start(st[1]), .tx_data(txd[1]), .tx_busy(busy[1]), .drop_cnt(drop[1]), .ack_err(aerr[1]));

  // UART: busy rises the cycle after tx_start is sampled and stays high busy_len cycles
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        busy[i] <= 1'b0;
        ucnt[i] <= 0;
      end else if (ucnt[i] > 0) begin
        ucnt[i] <= ucnt[i] - 1;
        if (ucnt[i] == 1) busy[i] <= 1'b0;
      end else if (st[i] && uart_en[i]) begin
        busy[i] <= 1'b1;
        ucnt[i] <= busy_len[i];
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (st[i] === 1'b1) begin
        if (i == 0) begin got0.push_back(txd[i]); sc0.push_back(cyc); end
        else begin got1.push_back(txd[i]); sc1.push_back(cyc); end
        if (busy[i]) viol++;
        last_b[i] = txd[i];
      end else if (busy[i] && (txd[i] !== last_b[i])) begin
        viol++;
      end
    end
  end

  function automatic int gsize(input int i);
    if (i == 0) return got0.size();
    return got1.size();
  endfunction

  function automatic int gbyte(input int i, input int k);
    if (i == 0) return int'(got0[k]);
    return int'(got1[k]);
  endfunction

  function automatic int gcyc(input int i, input int k);
    if (i == 0) return sc0[k];
    return sc1[k];
  endfunction

  function automatic bq_t model(input logic [7:0] v, input bit crlf);
    bq_t q;
    int t = int'($signed(v));
    int m = (t < 0) ? -t : t;
    q.push_back(8'h54);
    q.push_back((t < 0) ? 8'h2D : 8'h2B);
    q.push_back(8'(48 + m / 100));
    q.push_back(8'(48 + (m / 10) % 10));
    q.push_back(8'(48 + m % 10));
    if (crlf) q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_msg(input int i, input logic [7:0] v, input int blen, input bq_t exp, input string nm);
    int base, t, acc, b;
    busy_len[i] = blen;
    base = gsize(i);
    t = 0;
    while (rdy[i] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    chk({nm, " ready"}, rdy[i], 1);
    tv[i] = 1'b1; td[i] = v; acc = cyc;
    @(negedge clk);
    tv[i] = 1'b0;
    t = 0;
    while ((gsize(i) < base + exp.size() || rdy[i] !== 1'b1) && t < exp.size() * (blen + 20) + 50) begin
      @(negedge clk); t++;
    end
    @(negedge clk);
    chk({nm, " byte count"}, gsize(i) - base, exp.size());
    for (int k = 0; k < exp.size(); k++) begin
      b = (base + k < gsize(i)) ? gbyte(i, base + k) : 999;
      chk($sformatf("%s byte%0d", nm, k), b, int'(exp[k]));
    end
    if (gsize(i) > base) chk({nm, " latency"}, gcyc(i, base) - acc, 10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, base, d0, ns, ri, rb;
    logic [7:0]  rv;
    logic [55:0] w;
    bq_t e;

    vecs[0] = '{inst: 1'b0, val: 8'h19, blen: 1040, exp: 56'h542B3032350D0A, n: 7};
    vecs[1] = '{inst: 1'b0, val: 8'h80, blen: 12,   exp: 56'h542D3132380D0A, n: 7};
    vecs[2] = '{inst: 1'b0, val: 8'h00, blen: 5,    exp: 56'h542B3030300D0A, n: 7};
    vecs[3] = '{inst: 1'b1, val: 8'h7F, blen: 8,    exp: 56'h542B3132370A00, n: 6};
    vecs[4] = '{inst: 1'b1, val: 8'h80, blen: 3,    exp: 56'h542D3132380A00, n: 6};
    vecs[5] = '{inst: 1'b0, val: 8'hFF, blen: 1,    exp: 56'h542D3030310D0A, n: 7};
    vecs[6] = '{inst: 1'b0, val: 8'h64, blen: 2,    exp: 56'h542B3130300D0A, n: 7};
    vecs[7] = '{inst: 1'b0, val: 8'hFB, blen: 6,    exp: 56'h542D3030350D0A, n: 7};

    rst_n = 1'b0; tv = '0; td = '0;
    busy_len[0] = 4; busy_len[1] = 4; uart_en[0] = 1'b1; uart_en[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset ready", rdy[0], 0);
    chk("reset ready lf", rdy[1], 0);
    chk("reset tx_start", st[0], 0);
    chk("reset tx_data", txd[0], 0);
    chk("reset drop_cnt", drop[0], 0);
    chk("reset ack_err", aerr[0], 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after reset", rdy[0], 1);
    chk("ready after reset lf", rdy[1], 1);

    for (int v = 0; v < 8; v++) begin
      e = {};
      w = vecs[v].exp;
      for (int k = 0; k < vecs[v].n; k++) e.push_back(w[55 - 8 * k -: 8]);
      run_msg(int'(vecs[v].inst), vecs[v].val, vecs[v].blen, e, $sformatf("vec%0d", v));
    end

    // UART never answers: abort after ACK_TIMEOUT cycles
    uart_en[0] = 1'b0; base = gsize(0);
    chk("ack accept ready", rdy[0], 1);
    tv[0] = 1'b1; td[0] = 8'h11;
    @(negedge clk);
    tv[0] = 1'b0;
    t = 0;
    while (st[0] !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    chk("ack tx_start seen", st[0], 1);
    repeat (4) @(negedge clk);
    chk("ack_err before timeout", aerr[0], 0);
    chk("not ready while waiting ack", rdy[0], 0);
    @(negedge clk);
    chk("ack_err after timeout", aerr[0], 1);
    chk("ready after abort", rdy[0], 1);
    chk("abort single tx_start", gsize(0) - base, 1);
    uart_en[0] = 1'b1;
    run_msg(0, 8'h37, 3, model(8'h37, 1'b1), "after abort");
    chk("ack_err sticky", aerr[0], 1);

    // Strobe in the cycle the FSM returns to IDLE is dropped
    busy_len[0] = 4; base = gsize(0); d0 = int'(drop[0]);
    tv[0] = 1'b1; td[0] = 8'h0C;
    @(negedge clk);
    tv[0] = 1'b0;
    ns = 0; t = 0;
    while (ns < 7 && t < 200) begin @(negedge clk); t++; if (st[0] === 1'b1) ns++; end
    t = 0;
    while (busy[0] !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    while (busy[0] !== 1'b0 && t < 40) begin @(negedge clk); t++; end
    chk("return cycle not ready", rdy[0], 0);
    tv[0] = 1'b1; td[0] = 8'h0D;
    @(negedge clk);
    tv[0] = 1'b0;
    chk("idle after message", rdy[0], 1);
    chk("drop on return cycle", drop[0], d0 + 1);
    repeat (12) @(negedge clk);
    chk("no message from dropped strobe", gsize(0) - base, 7);

    // Reset in the middle of byte 3
    busy_len[0] = 20; base = gsize(0);
    tv[0] = 1'b1; td[0] = 8'h42;
    @(negedge clk);
    tv[0] = 1'b0;
    t = 0;
    while (gsize(0) < base + 3 && t < 300) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    tv[0] = 1'b1;
    @(negedge clk);
    tv[0] = 1'b0;
    chk("drop during message", drop[0], d0 + 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid reset tx_start", st[0], 0);
    chk("mid reset tx_data", txd[0], 0);
    chk("mid reset drop_cnt", drop[0], 0);
    chk("mid reset ack_err", aerr[0], 0);
    chk("mid reset ready", rdy[0], 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after mid reset", rdy[0], 1);
    base = gsize(0);
    repeat (20) @(negedge clk);
    chk("no resumed message", gsize(0) - base, 0);
    run_msg(0, 8'hFB, 6, model(8'hFB, 1'b1), "post reset -5");

    // Three strobes during a message
    fork
      run_msg(0, 8'h2A, 10, model(8'h2A, 1'b1), "drop3");
      begin
        repeat (20) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          tv[0] = 1'b1; td[0] = 8'hC3;
          @(negedge clk);
          tv[0] = 1'b0;
          repeat (4) @(negedge clk);
        end
      end
    join
    chk("drop_cnt after 3", drop[0], 3);

    // 300 strobes saturate the counter
    fork
      run_msg(0, 8'hD8, 60, model(8'hD8, 1'b1), "drop300");
      begin
        repeat (3) @(negedge clk);
        tv[0] = 1'b1; td[0] = 8'h01;
        repeat (300) @(negedge clk);
        tv[0] = 1'b0;
      end
    join
    chk("drop_cnt saturated", drop[0], 255);

    for (int n = 0; n < 24; n++) begin
      ri = int'($urandom_range(0, 1));
      rv = 8'($urandom_range(0, 255));
      rb = int'($urandom_range(1, 6));
      run_msg(ri, rv, rb, model(rv, ri == 0), $sformatf("rand%0d i%0d v%0h", n, ri, rv));
    end

    chk("tx protocol violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/temp_ascii_formatter.md
TEMP_ASCII_FORMATTER -- requirements
Module: temp_ascii_formatter

Interface
REQ-001 Parameter PREFIX, default 8'h54 ('T'), first byte of every message.
REQ-002 Parameter CRLF, default 1; 1 = terminate with 0x0D 0x0A, 0 = terminate with 0x0A only.
REQ-003 Parameter ACK_TIMEOUT, default 4, cycles allowed for tx_busy to rise after tx_start.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 temp_valid  in  1  one-cycle strobe, temp_data valid.
REQ-007 temp_data  in  8  signed two's-complement temperature, integer deg C.
REQ-008 ready  out  1  high only in IDLE; a sample is accepted when temp_valid=1 and ready=1.
REQ-009 tx_start  out  1  one-cycle pulse to UART transmitter.
REQ-010 tx_data  out  8  byte to transmit, stable from tx_start until tx_busy falls.
REQ-011 tx_busy  in  1  UART busy; rises the cycle after tx_start is sampled, falls when stop bit ends.
REQ-012 drop_cnt  out  8  saturating count of temp_valid strobes ignored while ready=0.
REQ-013 ack_err  out  1  sticky, set on handshake timeout.

Function
REQ-014 Message SHALL be PREFIX, sign ('+' 0x2B if temp_data>=0, '-' 0x2D otherwise), three ASCII decimal digits of |temp_data| with leading zeros, terminator per CRLF: 7 bytes (CRLF=1) or 6 bytes.
REQ-015 |temp_data| SHALL be computed as 8-bit unsigned; -128 yields magnitude 128 without overflow.
REQ-016 States: IDLE, CONV, LOAD, WAIT_ACK, WAIT_DONE.
REQ-017 IDLE: on accept, latch sign and magnitude, clear byte index, go CONV.
REQ-018 CONV: 8-cycle shift-and-add-3 binary-to-BCD, exactly one shift per cycle; then LOAD.
REQ-019 LOAD: drive tx_data = byte[index], pulse tx_start for one cycle, clear timeout counter, go WAIT_ACK.
REQ-020 First tx_start SHALL be asserted in cycle A+10 when the accept occurs at the edge ending cycle A (1 latch + 8 conversion + 1 load).
REQ-021 WAIT_ACK: on tx_busy=1 go WAIT_DONE; if ACK_TIMEOUT cycles pass without tx_busy=1, set ack_err, abort message, go IDLE.
REQ-022 WAIT_DONE: on tx_busy=0, if last byte go IDLE, else increment index and go LOAD.
REQ-023 tx_start SHALL never be asserted while tx_busy=1 or outside LOAD.
REQ-024 temp_valid while ready=0: sample discarded, drop_cnt incremented, saturating at 255; no effect on message in flight.
REQ-025 temp_valid in the same cycle that the FSM returns to IDLE is not accepted (ready is still 0) and counts as dropped.
REQ-026 ack_err and drop_cnt clear only by reset.

Reset
REQ-027 rst_n=0 at any clock edge, including mid-message, SHALL force IDLE, ready=0 during reset, tx_start=0, tx_data=0x00, drop_cnt=0, ack_err=0, index=0, BCD registers=0.
REQ-028 ready SHALL be 1 in the first cycle after rst_n returns high; no partial message resumes.

Structure
REQ-029 Shared package sensor_hub_pkg holds the ASCII constants (sign, digit base 0x30, CR, LF) and the FSM state enum.
REQ-030 BCD conversion SHALL be a sub-module bin2bcd8 (start, 8-bit binary in, done, 3x4-bit BCD out, 8-cycle latency).

Verification
REQ-031 temp_data=25 (0x19), CRLF=1, model UART busy 1040 cycles -> bytes 54 2B 30 32 35 0D 0A, one tx_start each.
REQ-032 temp_data=-128 (0x80) -> 54 2D 31 32 38 0D 0A; temp_data=0 -> 54 2B 30 30 30 0D 0A; CRLF=0 on 127 -> 54 2B 31 32 37 0A.
REQ-033 Three temp_valid strobes during a message -> drop_cnt=3, message bytes unchanged; 300 strobes -> drop_cnt=255.
REQ-034 tx_busy held 0 after tx_start -> ack_err=1 after 4 cycles, FSM back in IDLE, ready=1.
REQ-035 rst_n pulsed low during byte 3 -> tx_start=0, tx_data=0x00, drop_cnt=0, next temp_data=-5 yields 54 2D 30 30 35 0D 0A.
REQ-036 Accept-to-first-tx_start latency measured as exactly 10 cycles.
